// File: rtl/dmi_pkg.sv
// DMI data-register shared types: op and status encodings, FSM states and default widths.
package dmi_pkg;

    typedef enum logic [1:0] {NOP = 2'd0, READ = 2'd1, WRITE = 2'd2} dmi_op_e;
    typedef enum logic [1:0] {SUCCESS = 2'd0, FAILED = 2'd2, BUSY = 2'd3} dmi_status_e;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} dmi_state_e;

    localparam int DefAddrWidth     = 7;
    localparam int DefDataWidth     = 32;
    localparam int DefTimeoutCycles = 1024;

endpackage

// File: rtl/dmi_jtag_dr_if.sv
// DMI request/response channel between the DTM (master) and the debug module (slave).
interface dmi_jtag_dr_if #(
    parameter int AddrWidth = dmi_pkg::DefAddrWidth,
    parameter int DataWidth = dmi_pkg::DefDataWidth
);
    localparam int DrWidth = AddrWidth + DataWidth + 2;

    logic                 req_valid;
    logic                 req_ready;
    logic [DrWidth-1:0]   req;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [DataWidth-1:0] resp_data;
    logic                 resp_err;

    modport master (output req_valid, req, resp_ready,
                    input  req_ready, resp_valid, resp_data, resp_err);
    modport slave  (input  req_valid, req, resp_ready,
                    output req_ready, resp_valid, resp_data, resp_err);
endinterface

// File: rtl/dmi_dr_shreg.sv
// JTAG DR capture/shift register; load wins over shift, tdo is the LSB flop.
module dmi_dr_shreg #(
    parameter int DrWidth = 41
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [DrWidth-1:0] load_data_i,
    input  logic               shift_i,
    input  logic               tdi_i,
    output logic [DrWidth-1:0] dr_o,
    output logic               tdo_o
);
    logic [DrWidth-1:0] dr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      dr_q <= '0;
        else if (load_i)  dr_q <= load_data_i;
        else if (shift_i) dr_q <= {tdi_i, dr_q[DrWidth-1:1]};
    end

    assign dr_o  = dr_q;
    assign tdo_o = dr_q[0];
endmodule

// File: rtl/dmi_jtag_dr.sv
// DMI data-register engine behind the JTAG TAP: DR scan, DMI request/response, sticky dmistat.
// Optional request-to-response timeout enabled by DMI_JTAG_DR_TIMEOUT_EN.
module dmi_jtag_dr
    import dmi_pkg::*;
#(
    parameter int AddrWidth     = DefAddrWidth,
    parameter int DataWidth     = DefDataWidth,
    parameter int TimeoutCycles = DefTimeoutCycles
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          dmi_access_i,
    input  logic          capture_dr_i,
    input  logic          shift_dr_i,
    input  logic          update_dr_i,
    input  logic          tdi_i,
    output logic          tdo_o,
    input  logic          dmi_clear_i,
    output logic [1:0]    dmi_error_o,
    dmi_jtag_dr_if.master dmi
);
    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] data;
        logic [1:0]           op;
    } dmi_t;
    localparam int DrWidth = $bits(dmi_t);

    dmi_state_e           state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] data_q;
    logic [1:0]           op_q, error_q, error_d;
    logic [DrWidth-1:0]   dr_q, capture_val;
    dmi_t                 dr;
    logic                 capture, shift, update, accept, resp_fire, timeout;

    assign capture = dmi_access_i & capture_dr_i;
    assign shift   = dmi_access_i & shift_dr_i & ~capture_dr_i;
    assign update  = dmi_access_i & update_dr_i & ~capture_dr_i & ~shift_dr_i;

    assign dr          = dmi_t'(dr_q);
    assign capture_val = {addr_q, data_q, (state_q != IDLE) ? 2'(BUSY) : error_q};

    // A clear in the same cycle drops the update even when no error is pending.
    assign accept = update && !dmi_clear_i && error_q == 2'(SUCCESS) && state_q == IDLE &&
                    (dr.op == 2'(READ) || dr.op == 2'(WRITE));
    assign resp_fire = (state_q == WAIT) && dmi.resp_valid;

    dmi_dr_shreg #(.DrWidth(DrWidth)) i_shreg (
        .clk_i,
        .rst_ni,
        .load_i      (capture),
        .load_data_i (capture_val),
        .shift_i     (shift),
        .tdi_i,
        .dr_o        (dr_q),
        .tdo_o
    );

`ifdef DMI_JTAG_DR_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)               cnt_q <= '0;
        else if (accept)           cnt_q <= '0;
        else if (state_q != IDLE)  cnt_q <= cnt_q + CntW'(1);
    end

    // A response arriving in the last allowed cycle still completes normally.
    assign timeout = (state_q != IDLE) && (cnt_q == CntW'(TimeoutCycles - 1)) && !resp_fire;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (dmi.req_ready) state_d = WAIT;
            WAIT:    if (resp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = IDLE;
    end

    always_comb begin
        error_d = error_q;
        if (capture && state_q != IDLE) error_d = BUSY;
        if (update && error_q == 2'(SUCCESS) && state_q != IDLE) error_d = BUSY;
        if (resp_fire && dmi.resp_err && error_q == 2'(SUCCESS)) error_d = FAILED;
        if (timeout) error_d = FAILED;
        if (dmi_clear_i) error_d = SUCCESS;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= '0;
            error_q <= '0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            if (accept) begin
                addr_q <= dr.addr;
                data_q <= dr.data;
                op_q   <= dr.op;
            end else if (resp_fire && op_q == 2'(READ)) begin
                data_q <= dmi.resp_data;
            end
        end
    end

    assign dmi.req_valid  = (state_q == REQ);
    assign dmi.req        = {addr_q, data_q, op_q};
    assign dmi.resp_ready = (state_q == WAIT);
    assign dmi_error_o    = error_q;
endmodule
